// File: rtl/lia_pkg.sv
// Shared definitions for the lock-in averaging chain: sample width, block-size
// limits and the signed-to-unsigned magnitude helper.
package lia_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int LOG2_N_MIN = 1;
  localparam int LOG2_N_MAX = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [SAMPLE_W-1:0] usample_t;

  // Negation is done at full width and read back as unsigned, so the most negative
  // sample maps to 2**(W-1) instead of wrapping back to itself.
  function automatic usample_t abs_u(input sample_t s);
    return s[SAMPLE_W-1] ? usample_t'(-s) : usample_t'(s);
  endfunction

endpackage

// File: rtl/lia_mag_est.sv
// Two-stage alpha-max-beta-min magnitude estimator: |a|,|b| -> max + 3/8*min.
// Reused by the two-tone ratio stage, so it knows nothing about averaging.
module lia_mag_est
  import lia_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic                clk_100,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  output logic        [W-1:0] mag,
  output logic                mag_valid
);

  if (W != SAMPLE_W) begin : g_bad_width
    $error("lia_mag_est: W must equal lia_pkg::SAMPLE_W");
  end

  logic [W-1:0] abs_a, abs_b;
  logic [W-1:0] max_q, max_d, min_q, min_d;
  logic [W-1:0] mag_q, mag_d;
  logic         v2_q, v2_d, v3_q, v3_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    abs_a = abs_u(in_a);
    abs_b = abs_u(in_b);
    max_d = max_q;
    min_d = min_q;
    mag_d = mag_q;
    v2_d  = in_valid & ~clear;
    v3_d  = v2_q & ~clear;

    if (in_valid) begin
      if (abs_a >= abs_b) begin
        max_d = abs_a;
        min_d = abs_b;
      end else begin
        max_d = abs_b;
        min_d = abs_a;
      end
    end

    // max <= 2**(W-1) and min <= max, so the sum tops out at 1.375*2**(W-1).
    if (v3_d) begin
      mag_d = max_q + (min_q >> 2) + (min_q >> 3);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
      mag_q <= '0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
      mag_q <= mag_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
    end
  end

  assign mag       = mag_q;
  assign mag_valid = v3_q;

endmodule

// File: rtl/lia_boxcar_avg.sv
// Boxcar average and decimate one tone's demodulated X/Y over 2**LOG2_N samples,
// producing the block means and a magnitude estimate three cycles after each dump.
module lia_boxcar_avg
  import lia_pkg::*;
#(
  parameter int LOG2_N = 10,
  parameter int W      = SAMPLE_W
) (
  input  logic                clk_100,
  input  logic                rst_n,
  input  logic signed [W-1:0] sigin_x,
  input  logic signed [W-1:0] sigin_y,
  input  logic                sigin_valid,
  input  logic                clear,
  output logic signed [W-1:0] avg_x,
  output logic signed [W-1:0] avg_y,
  output logic        [W-1:0] mag,
  output logic                out_valid,
  output logic   [LOG2_N-1:0] sample_cnt
);

  if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX) begin : g_bad_log2_n
    $error("lia_boxcar_avg: LOG2_N out of range");
  end

  localparam int ACC_W = W + LOG2_N;

  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [ACC_W-1:0] sum_x, sum_y;
  logic        [LOG2_N-1:0] cnt_q, cnt_d;
  logic                     last_sample;

  logic signed [W-1:0] s1_ax_q, s1_ax_d, s1_ay_q, s1_ay_d;
  logic signed [W-1:0] s2_ax_q, s2_ax_d, s2_ay_q, s2_ay_d;
  logic signed [W-1:0] avg_x_q, avg_x_d, avg_y_q, avg_y_d;
  logic                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

  // Running sum including the current input; used both to accumulate and to dump.
  assign sum_x       = acc_x_q + {{LOG2_N{sigin_x[W-1]}}, sigin_x};
  assign sum_y       = acc_y_q + {{LOG2_N{sigin_y[W-1]}}, sigin_y};
  assign last_sample = (cnt_q == {LOG2_N{1'b1}});

  always_comb begin
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    cnt_d      = cnt_q;
    s1_valid_d = 1'b0;
    s1_ax_d    = s1_ax_q;
    s1_ay_d    = s1_ay_q;

    if (clear) begin
      acc_x_d = '0;
      acc_y_d = '0;
      cnt_d   = '0;
    end else if (sigin_valid) begin
      if (last_sample) begin
        // Mean of the finished block; the arithmetic shift rounds toward -inf.
        s1_valid_d = 1'b1;
        s1_ax_d    = W'(sum_x >>> LOG2_N);
        s1_ay_d    = W'(sum_y >>> LOG2_N);
        acc_x_d    = '0;
        acc_y_d    = '0;
        cnt_d      = '0;
      end else begin
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        cnt_d   = cnt_q + LOG2_N'(1);
      end
    end
  end

  // Delay line keeping avg_x/avg_y aligned with the estimator's two stages.
  always_comb begin
    s2_valid_d = s1_valid_q & ~clear;
    s2_ax_d    = s1_valid_q ? s1_ax_q : s2_ax_q;
    s2_ay_d    = s1_valid_q ? s1_ay_q : s2_ay_q;
    avg_x_d    = avg_x_q;
    avg_y_d    = avg_y_q;
    if (s2_valid_q && !clear) begin
      avg_x_d = s2_ax_q;
      avg_y_d = s2_ay_q;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_ax_q    <= '0;
      s1_ay_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_ax_q    <= '0;
      s2_ay_q    <= '0;
      avg_x_q    <= '0;
      avg_y_q    <= '0;
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_ax_q    <= s1_ax_d;
      s1_ay_q    <= s1_ay_d;
      s2_valid_q <= s2_valid_d;
      s2_ax_q    <= s2_ax_d;
      s2_ay_q    <= s2_ay_d;
      avg_x_q    <= avg_x_d;
      avg_y_q    <= avg_y_d;
    end
  end

  lia_mag_est #(.W(W)) u_mag_est (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (s1_valid_q),
    .in_a      (s1_ax_q),
    .in_b      (s1_ay_q),
    .mag       (mag),
    .mag_valid (out_valid)
  );

  assign avg_x      = avg_x_q;
  assign avg_y      = avg_y_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_lia_boxcar_avg.sv
// Directed bench for lia_boxcar_avg with 4-sample blocks: averaging, magnitude,
// strobe latency, valid gaps, clear and mid-operation reset.
module tb_lia_boxcar_avg;

  localparam int LOG2_N = 2;
  localparam int W      = 16;

  logic          clk_100     = 1'b0;
  logic          rst_n       = 1'b0;
  logic          sigin_valid = 1'b0;
  logic          clear       = 1'b0;
  logic [W-1:0]  sigin_x     = '0;
  logic [W-1:0]  sigin_y     = '0;
  logic [W-1:0]  avg_x, avg_y, mag;
  logic          out_valid;
  logic [LOG2_N-1:0] sample_cnt;

  always #5 clk_100 = ~clk_100;

  lia_boxcar_avg #(.LOG2_N(LOG2_N), .W(W)) dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .sigin_x     (sigin_x),
    .sigin_y     (sigin_y),
    .sigin_valid (sigin_valid),
    .clear       (clear),
    .avg_x       (avg_x),
    .avg_y       (avg_y),
    .mag         (mag),
    .out_valid   (out_valid),
    .sample_cnt  (sample_cnt)
  );

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] ax;
    logic [W-1:0] ay;
    logic [W-1:0] mg;
  } strobe_t;

  strobe_t strobes[$];
  strobe_t mon_s;

  // Record every out_valid strobe with the cycle it was seen in.
  always @(posedge clk_100) begin
    #1;
    if (out_valid) begin
      mon_s.cyc = cyc;
      mon_s.ax  = avg_x;
      mon_s.ay  = avg_y;
      mon_s.mg  = mag;
      strobes.push_back(mon_s);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic put(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    sigin_valid = v;
    sigin_x     = x;
    sigin_y     = y;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 16'd0, 16'd0);
  endtask

  task automatic block_const(input logic [W-1:0] x, input logic [W-1:0] y, output int dump);
    dump = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dump = cyc;
      put(1'b1, x, y);
    end
    sigin_valid = 1'b0;
  endtask

  task automatic expect_one(input string tag, input int dump,
                            input logic [W-1:0] ax, input logic [W-1:0] ay,
                            input logic [W-1:0] mg);
    strobe_t s;
    check({tag, "_count"}, strobes.size(), 1);
    if (strobes.size() > 0) begin
      s = strobes.pop_front();
      check({tag, "_lat"},   s.cyc - dump, 3);
      check({tag, "_avg_x"}, 32'(s.ax), 32'(ax));
      check({tag, "_avg_y"}, 32'(s.ay), 32'(ay));
      check({tag, "_mag"},   32'(s.mg), 32'(mg));
    end
    strobes.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  initial begin
    int d;
    int dumps[3];
    int gaps[4];
    logic [W-1:0] xs[4];
    strobe_t s;

    gaps = '{0, 2, 5, 3};
    xs   = '{16'd1, 16'd2, 16'd3, -16'sd7};

    // Reset state
    tick();
    tick();
    check("rst_avg_x", 32'(avg_x), 0);
    check("rst_avg_y", 32'(avg_y), 0);
    check("rst_mag", 32'(mag), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sample_cnt", 32'(sample_cnt), 0);
    rst_n = 1'b1;
    tick();

    // 1: continuous x=1000, three back-to-back blocks
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) dumps[b] = cyc;
        put(1'b1, 16'd1000, 16'd0);
        if (b == 0 && i == 1) check("t1_cnt2", 32'(sample_cnt), 2);
      end
    end
    sigin_valid = 1'b0;
    idle(5);
    check("t1_count", strobes.size(), 3);
    for (int b = 0; b < 3; b++) begin
      if (strobes.size() > 0) begin
        s = strobes.pop_front();
        check("t1_lat", s.cyc - dumps[b], 3);
        check("t1_avg_x", 32'(s.ax), 1000);
        check("t1_avg_y", 32'(s.ay), 0);
        check("t1_mag", 32'(s.mg), 1000);
      end
    end
    strobes.delete();

    // 2: x=300, y=-400 -> mag 400+75+37
    block_const(16'd300, -16'sd400, d);
    idle(5);
    expect_one("t2", d, 16'd300, 16'hFE70, 16'd512);

    // 3: full-scale negative, magnitude must not wrap
    block_const(16'h8000, 16'h8000, d);
    idle(5);
    expect_one("t3", d, 16'h8000, 16'h8000, 16'd45056);

    // 4: x = 1,2,3,-7 with gaps; sum -1 >>> 2 = -1
    d = 0;
    for (int i = 0; i < 4; i++) begin
      idle(gaps[i]);
      if (i == 2) check("t4_cnt_hold", 32'(sample_cnt), 2);
      if (i == 3) d = cyc;
      put(1'b1, xs[i], 16'd0);
    end
    sigin_valid = 1'b0;
    idle(5);
    expect_one("t4", d, 16'hFFFF, 16'd0, 16'd1);

    // 5: clear on the 4th sample discards the block; outputs hold
    for (int i = 0; i < 3; i++) put(1'b1, 16'd8, 16'd0);
    clear = 1'b1;
    put(1'b1, 16'd8, 16'd0);
    clear = 1'b0;
    idle(6);
    check("t5_no_strobe", strobes.size(), 0);
    check("t5_cnt", 32'(sample_cnt), 0);
    check("t5_hold_avg_x", 32'(avg_x), 32'h0000FFFF);
    check("t5_hold_mag", 32'(mag), 1);
    strobes.delete();
    block_const(16'd8, 16'd0, d);
    idle(5);
    expect_one("t5", d, 16'd8, 16'd0, 16'd8);

    // 6: reset with a result in S2; outputs zero at once, no strobe
    block_const(16'd100, 16'd0, d);
    put(1'b1, 16'd50, 16'd0);
    rst_n = 1'b0;
    #1;
    check("t6_avg_x", 32'(avg_x), 0);
    check("t6_mag", 32'(mag), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_cnt", 32'(sample_cnt), 0);
    put(1'b0, 16'd0, 16'd0);
    rst_n = 1'b1;
    idle(4);
    check("t6_no_strobe", strobes.size(), 0);
    strobes.delete();

    // 6b: reset with sample_cnt=3 drops the partial block
    for (int i = 0; i < 3; i++) put(1'b1, 16'd5, 16'd5);
    check("t6b_cnt3", 32'(sample_cnt), 3);
    rst_n = 1'b0;
    #1;
    check("t6b_cnt0", 32'(sample_cnt), 0);
    put(1'b0, 16'd0, 16'd0);
    rst_n = 1'b1;
    tick();

    // Next block after reset completes normally: x=-8, y=16 -> mag 16+2+1
    block_const(-16'sd8, 16'd16, d);
    idle(5);
    expect_one("t6_next", d, 16'hFFF8, 16'd16, 16'd19);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
